// File: rtl/multi_hot_encoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : multi_hot_encoder_seq
//  Description : Latches an N-bit request vector over a valid/ready handshake
//                and serialises the binary index of every set bit, lowest
//                index first, one index per beat on a second valid/ready
//                handshake. All-zero vectors are dropped and flagged with a
//                one-cycle pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_hot_encoder_seq #(
    parameter int N = 8,             // request vector width, 2..64
    parameter int W = $clog2(N)      // index width, derived from N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_vec,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_idx,
    output logic           out_last,
    output logic [W:0]     out_cnt,
    output logic           zero_pulse
);

    // ------------------------------------------------------------------------
    // State encoding and constants
    // ------------------------------------------------------------------------
    localparam logic [0:0]   c_IDLE = 1'b0;
    localparam logic [0:0]   c_EMIT = 1'b1;
    localparam logic [N-1:0] c_ONE  = {{(N-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    logic [0:0]   state_q, state_d;
    logic [N-1:0] pend_q,  pend_d;
    logic [W:0]   cnt_q,   cnt_d;
    logic         zero_q,  zero_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic         w_accept;     // input handshake this cycle
    logic         w_take;       // output handshake this cycle
    logic         w_vec_zero;   // presented vector has no bits set
    logic [W:0]   w_vec_cnt;    // popcount of the presented vector
    logic [N-1:0] w_pend_rest;  // pending bits with the lowest one cleared
    logic [W-1:0] w_low_idx;    // position of the lowest pending bit
    logic         w_is_last;    // exactly one pending bit remains

    assign w_accept    = in_valid & in_ready;
    assign w_take      = out_valid & out_ready;
    assign w_vec_zero  = (in_vec == '0);
    // x & (x-1) removes the lowest set bit; zero result means x was one-hot
    assign w_pend_rest = pend_q & (pend_q - c_ONE);
    assign w_is_last   = (pend_q != '0) && (w_pend_rest == '0);

    // Population count of the incoming vector, loaded into cnt on accept
    always_comb begin
        w_vec_cnt = '0;
        for (int i = 0; i < N; i++) begin
            w_vec_cnt = w_vec_cnt + (W+1)'(in_vec[i]);
        end
    end

    // Priority encoder: lowest set bit of the latched vector wins
    always_comb begin
        w_low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                w_low_idx = W'(i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // State register with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // Enter EMIT on a non-empty vector, return to IDLE after the last beat
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_accept && !w_vec_zero) begin
                    state_d = c_EMIT;
                end
            end
            c_EMIT: begin
                if (w_take && w_is_last) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------------
    // Outputs come from registers; en (and rst) only gate the handshakes
    always_comb begin
        in_ready   = en & ~rst & (state_q == c_IDLE);
        out_valid  = en & ~rst & (state_q == c_EMIT);
        out_idx    = w_low_idx;
        out_last   = w_is_last;
        out_cnt    = cnt_q;
        zero_pulse = zero_q;
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // Load pending bits on accept, strip the lowest bit on each taken beat
    always_comb begin
        pend_d = pend_q;
        cnt_d  = cnt_q;
        zero_d = w_accept & w_vec_zero;
        if (w_accept && !w_vec_zero) begin
            pend_d = in_vec;
            cnt_d  = w_vec_cnt;
        end else if (w_take) begin
            pend_d = w_pend_rest;
            if (w_is_last) begin
                cnt_d = '0;
            end
        end
    end

    // Datapath registers; the zero flag lives for exactly one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_hot_encoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_hot_encoder_seq
//  Description : Self-checking bench for multi_hot_encoder_seq. A queue of
//                pending indices models the block; directed scenarios are
//                followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_hot_encoder_seq;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk;
    logic         rst;
    logic         en;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic [W:0]   out_cnt;
    logic         zero_pulse;

    int n_vec;
    int n_err;

    // Reference model: indices still to be emitted, burst popcount, zero flag
    int mq[$];
    int mcnt;
    bit mzero;

    multi_hot_encoder_seq #(.N(N)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_cnt    (out_cnt),
        .zero_pulse (zero_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive inputs, compare against model, advance model
    task automatic step(input logic r, input logic e, input logic iv,
                        input logic [N-1:0] v, input logic ordy);
        bit busy;
        bit x_in_ready;
        bit x_out_valid;
        int x_idx;
        @(negedge clk);
        rst       = r;
        en        = e;
        in_valid  = iv;
        in_vec    = v;
        out_ready = ordy;
        #1;
        busy        = (mq.size() > 0);
        x_in_ready  = e && !r && !busy;
        x_out_valid = e && !r && busy;
        x_idx       = busy ? mq[0] : 0;
        check_val("in_ready",   64'(in_ready),   64'(x_in_ready));
        check_val("out_valid",  64'(out_valid),  64'(x_out_valid));
        check_val("out_idx",    64'(out_idx),    64'(x_idx));
        check_val("out_last",   64'(out_last),   64'(mq.size() == 1));
        check_val("out_cnt",    64'(out_cnt),    64'(mcnt));
        check_val("zero_pulse", 64'(zero_pulse), 64'(mzero));
        // advance model to the state after the coming rising edge
        if (r) begin
            mq.delete();
            mcnt  = 0;
            mzero = 0;
        end else begin
            mzero = x_in_ready && iv && (v == '0);
            if (x_in_ready && iv && (v != '0)) begin
                for (int i = 0; i < N; i++) begin
                    if (v[i]) mq.push_back(i);
                end
                mcnt = mq.size();
            end else if (x_out_valid && ordy) begin
                void'(mq.pop_front());
                if (mq.size() == 0) mcnt = 0;
            end
        end
    endtask

    initial begin
        logic [N-1:0] v;
        int           kind;
        n_vec     = 0;
        n_err     = 0;
        mcnt      = 0;
        mzero     = 0;
        rst       = 1'b1;
        en        = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);

        // reset state, including during reset with en high
        step(1, 1, 0, '0, 0);
        step(0, 1, 0, '0, 1);

        // single-bit vector
        step(0, 1, 1, 8'b0000_0100, 1);
        step(0, 1, 0, '0, 1);
        step(0, 1, 0, '0, 1);

        // four-bit burst, back-to-back beats
        step(0, 1, 1, 8'b1010_0110, 1);
        repeat (5) step(0, 1, 0, '0, 1);

        // consumer stalls three cycles
        step(0, 1, 1, 8'b1000_0001, 0);
        repeat (3) step(0, 1, 0, '0, 0);
        repeat (3) step(0, 1, 0, '0, 1);

        // zero vector dropped
        step(0, 1, 1, 8'b0000_0000, 1);
        repeat (2) step(0, 1, 0, '0, 1);

        // all ones with an enable stall after index 3
        step(0, 1, 1, 8'hFF, 1);
        repeat (4) step(0, 1, 0, '0, 1);
        repeat (2) step(0, 0, 1, 8'h01, 1);
        repeat (5) step(0, 1, 0, '0, 1);

        // reset mid-burst
        step(0, 1, 1, 8'b0000_1110, 1);
        step(0, 1, 0, '0, 1);
        step(1, 1, 0, '0, 1);
        repeat (3) step(0, 1, 0, '0, 1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                0:       v = '0;
                1:       v = '1;
                2, 3:    v = N'(1) << $urandom_range(0, N - 1);
                default: v = N'($urandom);
            endcase
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 50),
                 v,
                 ($urandom_range(0, 99) < 70));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
